// File: rtl/sd_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between an SD DMA (A) and a CPU (B), with read-ack routing.
// Optional per-requester transfer counters are enabled by defining SD_BUS_ARBITER_COUNTERS_EN.
module sd_bus_arbiter #(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TAG_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_a_request,
   input  logic        i_a_write,
   input  logic [3:0]  i_a_bank,
   input  logic [23:0] i_a_address,
   input  logic [31:0] i_a_data,
   output logic        o_a_busy,
   output logic        o_a_ack,
   input  logic        i_b_request,
   input  logic        i_b_write,
   input  logic [3:0]  i_b_bank,
   input  logic [23:0] i_b_address,
   input  logic [31:0] i_b_data,
   output logic        o_b_busy,
   output logic        o_b_ack,
   output logic        o_request,
   output logic        o_write,
   output logic [3:0]  o_bank,
   output logic [23:0] o_address,
   output logic [31:0] o_data,
   input  logic        i_busy,
   input  logic        i_ack,
   output logic [1:0]  o_grant
`ifdef SD_BUS_ARBITER_COUNTERS_EN
   ,
   output logic [15:0] o_a_count,
   output logic [15:0] o_b_count
`endif
);

   localparam int unsigned    PTR_W   = $clog2(TAG_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   // Encodings double as the registered o_grant value.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_A = 2'b01,
      GRANT_B = 2'b10
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic           last_b;
   logic [7:0]     burst_cnt;
   logic           tag_mem [TAG_DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;

   logic use_b;
   logic sel_req;
   logic sel_write;
   logic tag_empty;
   logic tag_full;
   logic tag_head;
   logic tag_full_block;
   logic accept;
   logic push;
   logic pop;
   logic burst_last;
   logic release_grant;
   logic grant_entry;

   assign use_b     = (state == GRANT_B);
   assign sel_req   = ((state == GRANT_A) && i_a_request) || ((state == GRANT_B) && i_b_request);
   assign sel_write = use_b ? i_b_write : i_a_write;

   assign tag_empty = (wr_ptr == rd_ptr);
   assign tag_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign tag_head  = tag_mem[rd_ptr[PTR_W-1:0]];

   // Only reads need a tag slot, so a full tag FIFO never holds up a write.
   assign tag_full_block = tag_full && (state != IDLE) && !sel_write;

   assign o_request = sel_req && !tag_full_block;
   assign o_write   = sel_write;
   assign o_bank    = use_b ? i_b_bank    : i_a_bank;
   assign o_address = use_b ? i_b_address : i_a_address;
   assign o_data    = use_b ? i_b_data    : i_a_data;
   assign o_grant   = state;

   assign accept = o_request && !i_busy;
   assign push   = accept && !sel_write;
   assign pop    = i_ack && !tag_empty;

   assign o_a_busy = !((state == GRANT_A) && !i_busy && !tag_full_block);
   assign o_b_busy = !((state == GRANT_B) && !i_busy && !tag_full_block);
   assign o_a_ack  = pop && !tag_head;
   assign o_b_ack  = pop && tag_head;

   assign burst_last    = accept && (burst_cnt == 8'(BURST_LEN - 1));
   assign release_grant = !sel_req || burst_last;
   assign grant_entry   = (state_nxt != IDLE) && (state_nxt != state);

   // NOTE: every signal written here gets a default first, otherwise a path that skips the assignment infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_a_request && i_b_request) state_nxt = last_b ? GRANT_A : GRANT_B;
            else if (i_a_request)           state_nxt = GRANT_A;
            else if (i_b_request)           state_nxt = GRANT_B;
         end
         GRANT_A: if (release_grant) state_nxt = i_b_request ? GRANT_B : IDLE;
         GRANT_B: if (release_grant) state_nxt = i_a_request ? GRANT_A : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         last_b    <= 1'b1;
         burst_cnt <= 8'd0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_entry) begin
            burst_cnt <= 8'd0;
            last_b    <= (state_nxt == GRANT_B);
         end else if (accept) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: tag storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push) tag_mem[wr_ptr[PTR_W-1:0]] <= use_b;
   end

`ifdef SD_BUS_ARBITER_COUNTERS_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_a_count <= 16'd0;
         o_b_count <= 16'd0;
      end else if (accept) begin
         if (!use_b && (o_a_count != 16'hFFFF)) o_a_count <= o_a_count + 16'd1;
         if (use_b  && (o_b_count != 16'hFFFF)) o_b_count <= o_b_count + 16'd1;
      end
   end
`endif

endmodule
